// File: rtl/ads_fifo_pkg.sv
// ads_fifo_pkg
// Shared definitions for the ADS sample FIFO: count-width helper, the G729
// framing constants and the error flag pair type.
package ads_fifo_pkg;

    // Default G729 framing constants (samples).
    localparam int FRAME_LEN_G729  = 80;
    localparam int WINDOW_LEN_G729 = 240;

    // A word count must represent 0..2**addr_w inclusive, hence one extra bit.
    function automatic int count_width(input int addr_w);
        return addr_w + 1;
    endfunction

    // Sticky error pair.
    typedef struct packed {
        logic ovf;   // a write was dropped because the FIFO was full
        logic udf;   // a read was refused because the FIFO was empty
    } err_flags_t;

endpackage

// File: rtl/ads_sdp_ram.sv
// ads_sdp_ram
// Simple dual-port RAM with one write port and one registered read port.
// The read register only loads when rd_en is high, so rd_data holds its last
// value otherwise. On a same-address read and write, the old word is returned.
// Ports:
//   clk      : clock
//   rst_n    : synchronous active-low reset (clears the read register only)
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write word
//   rd_en    : read strobe (loads rd_data on the next edge)
//   rd_addr  : read address
//   rd_data  : registered read word
module ads_sdp_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [DATA_W-1:0] rd_data_reg;

    // Storage is deliberately not reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/ads_frame_fifo.sv
// ads_frame_fifo
// Single-clock sample FIFO between the high-pass filter and the LPC stage.
// Holds the pointers, the word count, the status flags and the sticky errors;
// the storage lives in ads_sdp_ram.
// Ports:
//   sys_clk, sys_rst_n : clock and synchronous active-low reset
//   sys_ce             : clock enable; when low all state holds, rd_valid is 0
//   flush              : clears pointers/count, overrides wr_en/rd_en
//   err_clr            : clears ovf_err/udf_err (a coincident new error wins)
//   wr_en, wr_data     : write request and sample
//   rd_en              : read request; rd_data/rd_valid follow one cycle later
//   count              : stored words, 0..DEPTH
//   full, empty, almost_full, almost_empty, frame_ready : decodes of count
//   ovf_err, udf_err   : sticky overflow / underflow
module ads_frame_fifo
    import ads_fifo_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 12,
    parameter int FRAME_LEN = FRAME_LEN_G729,
    parameter int AF_LEVEL  = (2 ** ADDR_W) - 4,
    parameter int AE_LEVEL  = 4
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic                          sys_ce,
    input  logic                          flush,
    input  logic                          err_clr,
    input  logic                          wr_en,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          rd_en,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          rd_valid,
    output logic [count_width(ADDR_W)-1:0] count,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic                          frame_ready,
    output logic                          ovf_err,
    output logic                          udf_err
);

    localparam int CNT_W = count_width(ADDR_W);
    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);
    localparam logic [CNT_W-1:0] FRAME_C = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    // Pointers carry a wrap bit above the address bits.
    logic [CNT_W-1:0] wr_ptr_reg;
    logic [CNT_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    err_flags_t       err_reg;
    logic             rd_valid_reg;

    logic active;
    logic rd_acc;
    logic wr_acc;
    logic ovf_set;
    logic udf_set;

    // Flags are pure decodes of the registered count.
    assign full         = (count_reg == DEPTH_C);
    assign empty        = (count_reg == '0);
    assign almost_full  = (count_reg >= AF_C);
    assign almost_empty = (count_reg <= AE_C);
    assign frame_ready  = (count_reg >= FRAME_C);

    always_comb begin
        active  = sys_ce & ~flush;
        rd_acc  = active & rd_en & ~empty;
        // A write into a full FIFO is fine when a read frees a slot this cycle.
        wr_acc  = active & wr_en & (~full | rd_acc);
        ovf_set = active & wr_en & full & ~rd_acc;
        udf_set = active & rd_en & empty;
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            err_reg      <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= rd_acc;
            if (sys_ce) begin
                if (flush) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (wr_acc) begin
                        wr_ptr_reg <= wr_ptr_reg + ONE_C;
                    end
                    if (rd_acc) begin
                        rd_ptr_reg <= rd_ptr_reg + ONE_C;
                    end
                    if (wr_acc && !rd_acc) begin
                        count_reg <= count_reg + ONE_C;
                    end else if (rd_acc && !wr_acc) begin
                        count_reg <= count_reg - ONE_C;
                    end
                end
                // Set has priority over clear.
                err_reg.ovf <= ovf_set | (err_reg.ovf & ~err_clr);
                err_reg.udf <= udf_set | (err_reg.udf & ~err_clr);
            end
        end
    end

    assign count    = count_reg;
    assign rd_valid = rd_valid_reg;
    assign ovf_err  = err_reg.ovf;
    assign udf_err  = err_reg.udf;

    ads_sdp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (sys_clk),
        .rst_n   (sys_rst_n),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_reg[ADDR_W-1:0]),
        .wr_data (wr_data),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr_reg[ADDR_W-1:0]),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_ads_frame_fifo.sv
// tb_ads_frame_fifo
// Directed bench for ads_frame_fifo with DATA_W=16, ADDR_W=4 (DEPTH=16),
// FRAME_LEN=8, AF_LEVEL=14, AE_LEVEL=2. Inputs change 1 time unit after the
// rising edge; outputs are sampled at the same point, away from the edge.
module tb_ads_frame_fifo;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;

    logic              sys_clk = 1'b0;
    logic              sys_rst_n;
    logic              sys_ce;
    logic              flush;
    logic              err_clr;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic              frame_ready;
    logic              ovf_err;
    logic              udf_err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 sys_clk = ~sys_clk;

    ads_frame_fifo #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .FRAME_LEN (8),
        .AF_LEVEL  (14),
        .AE_LEVEL  (2)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .sys_ce       (sys_ce),
        .flush        (flush),
        .err_clr      (err_clr),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .frame_ready  (frame_ready),
        .ovf_err      (ovf_err),
        .udf_err      (udf_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_write(input logic [DATA_W-1:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
        $display("write 0x%04h count=%0d", d, count);
    endtask

    task automatic do_read(input string tag, input logic [DATA_W-1:0] exp);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        $display("read  0x%04h valid=%0b count=%0d", rd_data, rd_valid, count);
        check({tag, ".valid"}, 32'(rd_valid), 32'd1);
        check({tag, ".data"}, 32'(rd_data), 32'(exp));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".count"}, 32'(count), 32'd0);
        check({tag, ".empty"}, 32'(empty), 32'd1);
        check({tag, ".almost_empty"}, 32'(almost_empty), 32'd1);
        check({tag, ".full"}, 32'(full), 32'd0);
        check({tag, ".almost_full"}, 32'(almost_full), 32'd0);
        check({tag, ".frame_ready"}, 32'(frame_ready), 32'd0);
        check({tag, ".rd_valid"}, 32'(rd_valid), 32'd0);
        check({tag, ".rd_data"}, 32'(rd_data), 32'd0);
        check({tag, ".ovf_err"}, 32'(ovf_err), 32'd0);
        check({tag, ".udf_err"}, 32'(udf_err), 32'd0);
    endtask

    initial begin
        sys_rst_n = 1'b0;
        sys_ce    = 1'b1;
        flush     = 1'b0;
        err_clr   = 1'b0;
        wr_en     = 1'b0;
        wr_data   = '0;
        rd_en     = 1'b0;
        tick();
        tick();
        sys_rst_n = 1'b1;
        check_reset_state("reset");

        // 1: eight writes, then eight reads in order.
        for (int i = 1; i <= 8; i++) begin
            do_write(16'(i));
            if (i == 2) check("s1.ae_after2", 32'(almost_empty), 32'd1);
            if (i == 3) check("s1.ae_after3", 32'(almost_empty), 32'd0);
            if (i == 7) check("s1.fr_after7", 32'(frame_ready), 32'd0);
        end
        check("s1.count", 32'(count), 32'd8);
        check("s1.frame_ready", 32'(frame_ready), 32'd1);
        for (int i = 1; i <= 8; i++) do_read("s1.rd", 16'(i));
        check("s1.empty", 32'(empty), 32'd1);
        tick();
        check("s1.valid_drop", 32'(rd_valid), 32'd0);
        check("s1.data_hold", 32'(rd_data), 32'h8);

        // 2: seventeen writes; the last is dropped.
        for (int i = 1; i <= 17; i++) begin
            do_write(16'(i));
            if (i == 13) check("s2.af_after13", 32'(almost_full), 32'd0);
            if (i == 14) check("s2.af_after14", 32'(almost_full), 32'd1);
            if (i == 15) check("s2.full_after15", 32'(full), 32'd0);
            if (i == 16) check("s2.full_after16", 32'(full), 32'd1);
            if (i == 16) check("s2.ovf_before", 32'(ovf_err), 32'd0);
        end
        check("s2.ovf", 32'(ovf_err), 32'd1);
        check("s2.count", 32'(count), 32'd16);
        for (int i = 1; i <= 16; i++) do_read("s2.rd", 16'(i));
        check("s2.empty", 32'(empty), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("s2.ovf_clr", 32'(ovf_err), 32'd0);

        // 3: advance pointers so both wrap during the streaming phase, fill,
        // then 20 cycles of simultaneous write and read while full.
        for (int i = 0; i < 4; i++) begin
            do_write(16'h0050 + 16'(i));
            do_read("s3.pre", 16'h0050 + 16'(i));
        end
        for (int i = 1; i <= 16; i++) do_write(16'h0100 + 16'(i));
        check("s3.full", 32'(full), 32'd1);
        for (int k = 0; k < 20; k++) begin
            wr_en   = 1'b1;
            rd_en   = 1'b1;
            wr_data = 16'h0200 + 16'(k);
            tick();
            $display("stream wr 0x%04h rd 0x%04h valid=%0b count=%0d", wr_data, rd_data, rd_valid, count);
            check("s3.valid", 32'(rd_valid), 32'd1);
            check("s3.data", 32'(rd_data),
                  (k < 16) ? 32'h0100 + 32'(k + 1) : 32'h0200 + 32'(k - 16));
            check("s3.count", 32'(count), 32'd16);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("s3.ovf", 32'(ovf_err), 32'd0);
        for (int k = 4; k < 20; k++) do_read("s3.drain", 16'h0200 + 16'(k));
        check("s3.empty", 32'(empty), 32'd1);

        // 4: write+read on empty; read refused.
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        wr_data = 16'h0055;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("s4.udf", 32'(udf_err), 32'd1);
        check("s4.count", 32'(count), 32'd1);
        check("s4.rd_valid", 32'(rd_valid), 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("s4.udf_clr", 32'(udf_err), 32'd0);
        check("s4.ovf_clr", 32'(ovf_err), 32'd0);
        do_read("s4.rd", 16'h0055);
        err_clr = 1'b1;
        rd_en   = 1'b1;
        tick();
        err_clr = 1'b0;
        rd_en   = 1'b0;
        check("s4.set_wins", 32'(udf_err), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // 5: flush with wr_en and rd_en.
        for (int i = 0; i < 10; i++) do_write(16'h0300 + 16'(i));
        check("s5.count10", 32'(count), 32'd10);
        flush   = 1'b1;
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        wr_data = 16'hDEAD;
        tick();
        flush = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("s5.count", 32'(count), 32'd0);
        check("s5.empty", 32'(empty), 32'd1);
        check("s5.rd_valid", 32'(rd_valid), 32'd0);
        check("s5.ovf", 32'(ovf_err), 32'd0);
        check("s5.udf", 32'(udf_err), 32'd0);
        check("s5.rd_data_hold", 32'(rd_data), 32'h0055);
        do_write(16'hABCD);
        do_read("s5.rd", 16'hABCD);

        // 6: clock enable low holds state; reset overrides it.
        for (int i = 0; i < 5; i++) do_write(16'h0400 + 16'(i));
        sys_ce = 1'b0;
        wr_en  = 1'b1;
        rd_en  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("s6.count", 32'(count), 32'd5);
            check("s6.rd_valid", 32'(rd_valid), 32'd0);
        end
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        sys_rst_n = 1'b0;
        tick();
        check_reset_state("s6.reset");
        sys_rst_n = 1'b1;
        sys_ce    = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
